key_sample_frontend: RTL and testbench

KEY_SAMPLE_FRONTEND -- requirements
Module: key_sample_frontend

---
 rtl/key_sample_frontend.sv | 159 +++++++++++++++
 tb/tb_key_sample_frontend.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sample_frontend.sv
// key_sample_frontend
//   Turns a bouncing, asynchronous, active-low pushbutton into exactly one
//   sample offer per press. It hands the 3x3 switch image to a BP network
//   over a valid/ready handshake, waits (bounded) for the classification and
//   shows it on a seven-segment display.
//
// Ports
//   clk           rising-edge clock for every flop
//   rst_n         synchronous active-low reset
//   key           pushbutton, active-low, asynchronous to clk
//   sw[8:0]       switch image, sampled when a press is accepted
//   sample_valid  sample offered to the network (registered)
//   sample_ready  network accepts the sample
//   sample_data   latched switch image (registered)
//   result_valid  one-cycle classification strobe
//   result_class  classification value
//   led[6:0]      seven-segment drive {g,f,e,d,c,b,a}, active-low (registered)
//   busy          a transaction is in flight (ISSUE or WAIT)
//
// state | meaning
// IDLE  | nothing shown yet, waiting for a press
// ISSUE | sample offered, waiting for sample_ready
// WAIT  | sample taken, waiting for result or timeout
// SHOW  | result (or "E") on display, waiting for next press

module key_sample_frontend #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  input  logic [8:0] sw,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic [8:0] sample_data,
  input  logic       result_valid,
  input  logic [3:0] result_class,
  output logic [6:0] led,
  output logic       busy
);

  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] LED_BLANK = 7'b1111111;
  localparam logic [6:0] LED_ERR   = 7'b0000110;
  localparam logic [6:0] LED_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  state_t      state;
  logic        key_m;
  logic        key_s;
  logic [7:0]  db_cnt;
  logic [7:0]  rel_cnt;
  logic        armed;
  logic [15:0] to_cnt;
  logic        accept;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = LED_DASH;
    endcase
    return s;
  endfunction

  // Two-flop synchronizer; idles high so reset does not look like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      key_m <= key;
      key_s <= key_m;
    end
  end

  // db_cnt counts consecutive lows, rel_cnt consecutive highs. The press is
  // accepted once per low run; re-arming needs a full debounce of release so
  // bounce on key-up cannot produce a second acceptance.
  assign accept = !key_s && (db_cnt == DB_LAST) && armed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt  <= '0;
      rel_cnt <= '0;
      armed   <= 1'b1;
    end else if (!key_s) begin
      rel_cnt <= '0;
      if (db_cnt != DB_LAST) db_cnt <= db_cnt + 8'd1;
      if (accept) armed <= 1'b0;
    end else begin
      db_cnt <= '0;
      if (rel_cnt == DB_LAST) armed <= 1'b1;
      else                    rel_cnt <= rel_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      led          <= LED_BLANK;
      to_cnt       <= '0;
    end else begin
      case (state)
        S_IDLE, S_SHOW: begin
          // led is left alone so the previous result stays visible.
          if (accept) begin
            state        <= S_ISSUE;
            sample_valid <= 1'b1;
            sample_data  <= sw;
          end
        end
        S_ISSUE: begin
          if (sample_valid && sample_ready) begin
            state        <= S_WAIT;
            sample_valid <= 1'b0;
            to_cnt       <= '0;
          end
        end
        S_WAIT: begin
          // Result is tested first so it wins over a simultaneous timeout.
          if (result_valid) begin
            led   <= seg_decode(result_class);
            state <= S_SHOW;
          end else if (to_cnt == TO_LAST) begin
            led   <= LED_ERR;
            state <= S_SHOW;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_ISSUE) || (state == S_WAIT);

endmodule

// File: tb/tb_key_sample_frontend.sv
// Bench for key_sample_frontend: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model built from run lengths and a transaction phase.
module tb_key_sample_frontend;

  localparam int D = 3;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key;
  logic [8:0] sw;
  logic       sample_valid;
  logic       sample_ready;
  logic [8:0] sample_data;
  logic       result_valid;
  logic [3:0] result_class;
  logic [6:0] led;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 0;

  always #5 clk = ~clk;

  key_sample_frontend #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .sw(sw),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .result_valid(result_valid),
    .result_class(result_class), .led(led), .busy(busy)
  );

  function automatic logic [6:0] exp_seg(input int c);
    case (c)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Behavioural model: key samples go through a two-deep delay line; a press
  // is a low run of at least D synchronized samples while armed, and the arm
  // returns after a high run of at least D. Transactions are a phase number.
  int         k1, k2, low_run, high_run, m_armed, m_phase, m_wait;
  logic       m_valid;
  logic [8:0] m_data;
  logic [6:0] m_led;

  always @(posedge clk) begin : model
    int ks;
    bit acc;
    if (!rst_n) begin
      k1 = 1; k2 = 1; low_run = 0; high_run = 0; m_armed = 1;
      m_phase = 0; m_wait = 0; m_valid = 0; m_data = '0; m_led = 7'h7F;
    end else begin
      ks = k2; k2 = k1; k1 = int'(key);
      if (ks == 0) begin low_run++; high_run = 0; end
      else         begin high_run++; low_run = 0; end
      acc = (ks == 0) && (low_run >= D) && (m_armed == 1);
      if (acc) m_armed = 0;
      else if (ks == 1 && high_run >= D) m_armed = 1;
      case (m_phase)
        0, 3: if (acc) begin m_phase = 1; m_valid = 1; m_data = sw; end
        1: if (sample_ready) begin m_phase = 2; m_valid = 0; m_wait = 0; end
        2: begin
          m_wait++;
          if (result_valid) begin m_led = exp_seg(int'(result_class)); m_phase = 3; end
          else if (m_wait == T) begin m_led = 7'b0000110; m_phase = 3; end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_sample_valid", 32'(sample_valid), 32'(m_valid));
      cmp("model_sample_data", 32'(sample_data), 32'(m_data));
      cmp("model_led", 32'(led), 32'(m_led));
      cmp("model_busy", 32'(busy), 32'((m_phase == 1) || (m_phase == 2)));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int n);
    key = 1'b0;
    repeat (n) tick();
    key = 1'b1;
  endtask

  task automatic count_sv(input int n, inout int cnt);
    repeat (n) begin
      tick();
      if (sample_valid) cnt++;
    end
  endtask

  initial begin
    int sv_cnt;
    int hi;
    int key_left;
    int rv_div;

    rst_n = 1'b0; key = 1'b1; sw = '0; sample_ready = 1'b0;
    result_valid = 1'b0; result_class = '0;
    idle(2);
    chk_on = 1;
    cmp("reset_sample_valid", 32'(sample_valid), 32'd0);
    cmp("reset_sample_data", 32'(sample_data), 32'd0);
    cmp("reset_led", 32'(led), 32'h7F);
    cmp("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(4);

    // Basic transaction, ready tied high.
    sw = 9'h16A; sample_ready = 1'b1;
    press(5);
    cmp("basic_valid_rise", 32'(sample_valid), 32'd1);
    cmp("basic_data", 32'(sample_data), 32'h16A);
    tick();
    cmp("basic_valid_one_cycle", 32'(sample_valid), 32'd0);
    cmp("basic_busy_wait", 32'(busy), 32'd1);
    result_valid = 1'b1; result_class = 4'd4;
    tick();
    result_valid = 1'b0;
    cmp("basic_led_4", 32'(led), 32'b0011001);
    cmp("basic_busy_done", 32'(busy), 32'd0);
    cmp("model_pin_led_4", 32'(m_led), 32'b0011001);

    // A press of D-1 synchronized lows is rejected; exactly D lows accepted.
    idle(8);
    sv_cnt = 0;
    key = 1'b0; count_sv(D - 1, sv_cnt); key = 1'b1; count_sv(8, sv_cnt);
    cmp("short_press_rejected", 32'(sv_cnt), 32'd0);
    sv_cnt = 0;
    key = 1'b0; count_sv(D, sv_cnt); key = 1'b1; count_sv(5, sv_cnt);
    cmp("min_press_accepted", 32'(sv_cnt), 32'd1);
    result_valid = 1'b1; result_class = 4'd9;
    tick();
    result_valid = 1'b0;
    cmp("led_9", 32'(led), 32'b0010000);

    // Single-cycle glitches, then a held press: one acceptance only.
    idle(6);
    sv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      key = (i % 2 == 0) ? 1'b0 : 1'b1;
      count_sv(1, sv_cnt);
    end
    key = 1'b0; count_sv(6, sv_cnt); key = 1'b1; count_sv(6, sv_cnt);
    cmp("glitch_single_accept", 32'(sv_cnt), 32'd1);
    result_valid = 1'b1; result_class = 4'd4;
    tick();
    result_valid = 1'b0;
    cmp("glitch_led_4", 32'(led), 32'b0011001);

    // Back-pressure with sw changing while the sample is held.
    idle(6);
    sample_ready = 1'b0; sw = 9'h16A;
    press(5);
    hi = sample_valid ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) sw = 9'h0F5;
      tick();
      if (sample_valid) hi++;
      cmp("hold_data", 32'(sample_data), 32'h16A);
    end
    cmp("hold_valid_cycles", 32'(hi), 32'd8);
    cmp("show_not_blanked", 32'(led), 32'b0011001);
    sample_ready = 1'b1;
    tick();
    cmp("hold_release", 32'(sample_valid), 32'd0);

    // Timeout lands on the T-th WAIT edge, not before.
    idle(T - 1);
    cmp("timeout_not_early_led", 32'(led), 32'b0011001);
    cmp("timeout_not_early_busy", 32'(busy), 32'd1);
    tick();
    cmp("timeout_led_E", 32'(led), 32'b0000110);
    cmp("timeout_busy", 32'(busy), 32'd0);

    // Second transaction keeps E on display until its result arrives.
    idle(4);
    press(5);
    cmp("second_issue", 32'(sample_valid), 32'd1);
    cmp("second_keeps_E", 32'(led), 32'b0000110);
    tick();
    result_valid = 1'b1; result_class = 4'd12;
    tick();
    result_valid = 1'b0;
    cmp("class12_dash", 32'(led), 32'b0111111);

    // Result on the same edge as the timeout wins.
    idle(4);
    press(5);
    tick();
    idle(T - 1);
    result_valid = 1'b1; result_class = 4'd7;
    tick();
    result_valid = 1'b0;
    cmp("result_beats_timeout", 32'(led), 32'b1111000);

    // Reset in WAIT aborts; a late result is ignored.
    idle(4);
    press(5);
    tick();
    idle(3);
    cmp("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cmp("wait_reset_led", 32'(led), 32'h7F);
    cmp("wait_reset_busy", 32'(busy), 32'd0);
    cmp("wait_reset_valid", 32'(sample_valid), 32'd0);
    result_valid = 1'b1; result_class = 4'd3;
    tick();
    result_valid = 1'b0;
    cmp("late_result_ignored", 32'(led), 32'h7F);
    cmp("late_result_busy", 32'(busy), 32'd0);

    // Randomized traffic; the model compare checks every cycle.
    key_left = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (key_left == 0) begin
        key = ~key;
        key_left = key ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 6));
      end
      key_left--;
      rv_div = (c < 2000) ? 8 : 40;
      sample_ready = ($urandom % 4) != 0;
      result_valid = ($urandom % rv_div) == 0;
      result_class = 4'($urandom);
      sw           = 9'($urandom);
      rst_n        = ($urandom % 400) != 0;
    end
    tick();
    chk_on = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
